// File: rtl/roundkey_gen.sv
// -----------------------------------------------------------------------------
// roundkey_gen : AES-128 round-key producer.
//
// A 128-bit cipher key is accepted when i_key_valid & o_key_ready. It is then
// expanded one round key per cycle (NR cycles) into an internal array of NR+1
// round keys. Once READY, any stored key can be read through a registered,
// indexed port at one key per cycle, in any order.
//
// Ports
//   clk          : clock, all state on rising edge
//   rst          : asynchronous reset, active-low
//   i_key_valid  : cipher key present on i_key
//   i_key        : cipher key, word 0 in [127:96]
//   o_key_ready  : a key can be accepted this cycle (IDLE or READY)
//   i_rk_req     : round-key read request
//   i_rk_idx     : requested round index, 0..NR
//   o_rk_valid   : o_roundkey / o_rk_idx valid this cycle
//   o_rk_idx     : echo of the index being returned
//   o_roundkey   : round key for o_rk_idx
//   o_rk_err     : one-cycle pulse, request rejected (bad index or not READY)
// -----------------------------------------------------------------------------

// Forward AES S-box, computed as GF(2^8) inverse followed by the affine map.
module aes_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  function automatic logic [7:0] xtime8(input logic [7:0] a);
    logic [7:0] r;
    if (a[7]) begin
      r = {a[6:0], 1'b0} ^ 8'h1b;
    end else begin
      r = {a[6:0], 1'b0};
    end
    return r;
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        acc = acc ^ sh;
      end else begin
        acc = acc;
      end
      sh = xtime8(sh);
    end
    return acc;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8); it also maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = x;
    acc = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  // S-box lookup.
  always_comb begin
    o_byte = affine(gf_inv(i_byte));
  end

endmodule

module roundkey_gen #(
  parameter int WORD = 32,
  parameter int NB   = 4,
  parameter int NK   = 4,
  parameter int NR   = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_key_valid,
  input  logic [WORD*NK-1:0]   i_key,
  output logic                 o_key_ready,
  input  logic                 i_rk_req,
  input  logic [3:0]           i_rk_idx,
  output logic                 o_rk_valid,
  output logic [3:0]           o_rk_idx,
  output logic [WORD*NB-1:0]   o_roundkey,
  output logic                 o_rk_err
);

  localparam int         KW       = WORD * NB;
  localparam logic [3:0] LAST_IDX = 4'(NR);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_READY  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [KW-1:0] w_q, w_d;
  logic [7:0]    rcon_q, rcon_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [KW-1:0] rk_q [0:NR];
  logic [KW-1:0] rk_d [0:NR];

  logic          rk_valid_q, rk_valid_d;
  logic          rk_err_q, rk_err_d;
  logic [3:0]    rk_idx_q, rk_idx_d;
  logic [KW-1:0] roundkey_q, roundkey_d;

  logic [31:0]   rot_w;
  logic [31:0]   sub_w;
  logic [31:0]   t_w;
  logic [31:0]   w0_n, w1_n, w2_n, w3_n;
  logic [KW-1:0] w_next;
  logic [7:0]    rcon_next;
  logic [KW-1:0] rd_sel;

  // RotWord: rotate the last word of W left by one byte.
  assign rot_w = {w_q[23:0], w_q[31:24]};

  genvar g;
  for (g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .i_byte (rot_w[8*g +: 8]),
      .o_byte (sub_w[8*g +: 8])
    );
  end

  // Next work register: one key-schedule round applied to W.
  always_comb begin
    t_w       = sub_w ^ {rcon_q, 24'h000000};
    w0_n      = w_q[127:96] ^ t_w;
    w1_n      = w_q[95:64]  ^ w0_n;
    w2_n      = w_q[63:32]  ^ w1_n;
    w3_n      = w_q[31:0]   ^ w2_n;
    w_next    = {w0_n, w1_n, w2_n, w3_n};
    rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
  end

  // Read mux over the stored key array; out-of-range indices select zero.
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i <= NR; i++) begin
      if (i_rk_idx == 4'(i)) begin
        rd_sel = rk_q[i];
      end else begin
        rd_sel = rd_sel;
      end
    end
  end

  // Key-load and expansion control.
  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    rcon_d  = rcon_q;
    cnt_d   = cnt_q;
    for (int i = 0; i <= NR; i++) begin
      rk_d[i] = rk_q[i];
    end
    case (state_q)
      ST_IDLE, ST_READY: begin
        if (i_key_valid) begin
          rk_d[0] = i_key;
          w_d     = i_key;
          rcon_d  = 8'h01;
          cnt_d   = 4'd1;
          state_d = ST_EXPAND;
        end else begin
          state_d = state_q;
        end
      end
      ST_EXPAND: begin
        w_d    = w_next;
        rcon_d = rcon_next;
        cnt_d  = cnt_q + 4'd1;
        for (int i = 1; i <= NR; i++) begin
          if (cnt_q == 4'(i)) begin
            rk_d[i] = w_next;
          end else begin
            rk_d[i] = rk_q[i];
          end
        end
        if (cnt_q == LAST_IDX) begin
          state_d = ST_READY;
        end else begin
          state_d = ST_EXPAND;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Read port: reads use the array as it stands at the request edge, so a
  // request coinciding with a new key accept still sees the old keys.
  always_comb begin
    rk_valid_d = 1'b0;
    rk_err_d   = 1'b0;
    rk_idx_d   = rk_idx_q;
    roundkey_d = roundkey_q;
    if (i_rk_req) begin
      if ((state_q == ST_READY) && (i_rk_idx <= LAST_IDX)) begin
        rk_valid_d = 1'b1;
        rk_idx_d   = i_rk_idx;
        roundkey_d = rd_sel;
      end else begin
        rk_err_d = 1'b1;
      end
    end else begin
      rk_valid_d = 1'b0;
    end
  end

  // State, key array and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      w_q        <= '0;
      rcon_q     <= 8'h00;
      cnt_q      <= 4'd0;
      for (int i = 0; i <= NR; i++) begin
        rk_q[i] <= '0;
      end
      rk_valid_q <= 1'b0;
      rk_err_q   <= 1'b0;
      rk_idx_q   <= 4'd0;
      roundkey_q <= '0;
    end else begin
      state_q    <= state_d;
      w_q        <= w_d;
      rcon_q     <= rcon_d;
      cnt_q      <= cnt_d;
      for (int i = 0; i <= NR; i++) begin
        rk_q[i] <= rk_d[i];
      end
      rk_valid_q <= rk_valid_d;
      rk_err_q   <= rk_err_d;
      rk_idx_q   <= rk_idx_d;
      roundkey_q <= roundkey_d;
    end
  end

  assign o_key_ready = (state_q != ST_EXPAND);
  assign o_rk_valid  = rk_valid_q;
  assign o_rk_err    = rk_err_q;
  assign o_rk_idx    = rk_idx_q;
  assign o_roundkey  = roundkey_q;

endmodule

// File: tb/tb_roundkey_gen.sv
// Testbench for roundkey_gen: FIPS-197 vectors plus a key-schedule reference
// model built from the FIPS word recurrence, with a table S-box derived from
// exp/log tables over generator 3.
module tb_roundkey_gen;

  localparam int NR = 10;
  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_key_valid = 1'b0;
  logic [127:0] i_key = '0;
  logic         o_key_ready;
  logic         i_rk_req = 1'b0;
  logic [3:0]   i_rk_idx = '0;
  logic         o_rk_valid;
  logic [3:0]   o_rk_idx;
  logic [127:0] o_roundkey;
  logic         o_rk_err;

  int total = 0;
  int bad   = 0;

  logic [7:0]   sbox_t [256];
  logic [127:0] exp_rk [11];
  logic [127:0] old_rk [11];
  logic [127:0] last_out = '0;

  always #5 clk = ~clk;

  roundkey_gen dut (
    .clk         (clk),
    .rst         (rst),
    .i_key_valid (i_key_valid),
    .i_key       (i_key),
    .o_key_ready (o_key_ready),
    .i_rk_req    (i_rk_req),
    .i_rk_idx    (i_rk_idx),
    .o_rk_valid  (o_rk_valid),
    .o_rk_idx    (o_rk_idx),
    .o_roundkey  (o_roundkey),
    .o_rk_err    (o_rk_err)
  );

  function automatic logic [7:0] xt(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rol8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] ex [256];
    int         lg [256];
    logic [7:0] p;
    logic [7:0] b;
    p = 8'h01;
    for (int i = 0; i < 255; i++) begin
      ex[i] = p;
      lg[p] = i;
      p = p ^ xt(p);
    end
    sbox_t[0] = 8'h63;
    for (int x = 1; x < 256; x++) begin
      b = ex[(255 - lg[x]) % 255];
      sbox_t[x] = b ^ rol8(b, 1) ^ rol8(b, 2) ^ rol8(b, 3) ^ rol8(b, 4) ^ 8'h63;
    end
  endtask

  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]}
              ^ {rc, 24'h000000};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int k = 0; k <= NR; k++) exp_rk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endtask

  task automatic do_load(input logic [127:0] key);
    i_key_valid = 1'b1;
    i_key = key;
    @(negedge clk);
    i_key_valid = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (o_key_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    @(negedge clk);
    total++;
    if ({o_rk_valid, o_rk_err, o_rk_idx, o_roundkey, o_key_ready} !== {1'b0, 1'b0, 4'd0, 128'd0, 1'b1}) begin
      bad++;
      $display("FAIL reset_outputs got v=%b e=%b i=%0d k=%h rdy=%b want 0/0/0/0/1",
               o_rk_valid, o_rk_err, o_rk_idx, o_roundkey, o_key_ready);
    end
    rst = 1'b1;
    i_rk_req = 1'b1;
    i_rk_idx = 4'd0;
    @(negedge clk);
    i_rk_req = 1'b0;
    total++;
    if ({o_rk_valid, o_rk_err, o_roundkey} !== {1'b0, 1'b1, 128'd0}) begin
      bad++;
      $display("FAIL idle_req_err got v=%b e=%b k=%h want v=0 e=1 k=0", o_rk_valid, o_rk_err, o_roundkey);
    end
    @(negedge clk);
    total++;
    if ({o_rk_valid, o_rk_err} !== 2'b00) begin
      bad++;
      $display("FAIL err_one_pulse got v=%b e=%b want 0/0", o_rk_valid, o_rk_err);
    end
  endtask

  task automatic test_fips();
    int n;
    logic [127:0] lit [3];
    logic [3:0]   ids [3];
    lit[0] = K1;
    lit[1] = 128'ha0fafe1788542cb123a339392a6c7605;
    lit[2] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    ids[0] = 4'd0; ids[1] = 4'd1; ids[2] = 4'd10;
    do_load(K1);
    total++;
    if (o_key_ready !== 1'b0) begin
      bad++;
      $display("FAIL fips_busy got rdy=%b want 0", o_key_ready);
    end
    wait_ready(n);
    total++;
    if (n != NR) begin
      bad++;
      $display("FAIL fips_expand_len got %0d cycles want %0d", n, NR);
    end
    for (int k = 0; k < 3; k++) begin
      i_rk_req = 1'b1;
      i_rk_idx = ids[k];
      @(negedge clk);
      total++;
      if ({o_rk_valid, o_rk_err, o_rk_idx, o_roundkey} !== {1'b1, 1'b0, ids[k], lit[k]}) begin
        bad++;
        $display("FAIL fips_read got v=%b e=%b i=%0d k=%h want i=%0d k=%h",
                 o_rk_valid, o_rk_err, o_rk_idx, o_roundkey, ids[k], lit[k]);
      end
    end
    i_rk_req = 1'b0;
    last_out = lit[2];
    @(negedge clk);
    total++;
    if ({o_rk_valid, o_rk_err, o_roundkey} !== {1'b0, 1'b0, last_out}) begin
      bad++;
      $display("FAIL no_req_hold got v=%b e=%b k=%h want 0/0 k=%h", o_rk_valid, o_rk_err, o_roundkey, last_out);
    end
  endtask

  task automatic test_desc_burst();
    int n;
    model_expand(K2);
    do_load(K2);
    wait_ready(n);
    total++;
    if (n != NR) begin
      bad++;
      $display("FAIL desc_expand_len got %0d want %0d", n, NR);
    end
    for (int i = NR; i >= 0; i--) begin
      i_rk_req = 1'b1;
      i_rk_idx = 4'(i);
      @(negedge clk);
      total++;
      if ({o_rk_valid, o_rk_err, o_rk_idx, o_roundkey} !== {1'b1, 1'b0, 4'(i), exp_rk[i]}) begin
        bad++;
        $display("FAIL desc_read got v=%b i=%0d k=%h want i=%0d k=%h",
                 o_rk_valid, o_rk_idx, o_roundkey, i, exp_rk[i]);
      end
      if (i == NR) begin
        total++;
        if (o_roundkey !== 128'h13111d7fe3944a17f307a78b4d2b30c5) begin
          bad++;
          $display("FAIL desc_vec10 got %h want 13111d7fe3944a17f307a78b4d2b30c5", o_roundkey);
        end
      end
    end
    i_rk_req = 1'b0;
    last_out = exp_rk[0];
  endtask

  task automatic test_err();
    int n;
    do_load(K1);
    @(negedge clk);
    i_rk_req = 1'b1;
    i_rk_idx = 4'd3;
    total++;
    if (o_key_ready !== 1'b0) begin
      bad++;
      $display("FAIL err_busy got rdy=%b want 0", o_key_ready);
    end
    @(negedge clk);
    i_rk_req = 1'b0;
    total++;
    if ({o_rk_valid, o_rk_err, o_roundkey} !== {1'b0, 1'b1, last_out}) begin
      bad++;
      $display("FAIL err_expand got v=%b e=%b k=%h want v=0 e=1 k=%h", o_rk_valid, o_rk_err, o_roundkey, last_out);
    end
    wait_ready(n);
    total++;
    if (n != NR - 2) begin
      bad++;
      $display("FAIL err_remaining got %0d want %0d", n, NR - 2);
    end
    for (int k = 11; k <= 15; k += 4) begin
      i_rk_req = 1'b1;
      i_rk_idx = 4'(k);
      @(negedge clk);
      total++;
      if ({o_rk_valid, o_rk_err, o_roundkey} !== {1'b0, 1'b1, last_out}) begin
        bad++;
        $display("FAIL err_range idx=%0d got v=%b e=%b k=%h want v=0 e=1 k=%h",
                 k, o_rk_valid, o_rk_err, o_roundkey, last_out);
      end
    end
    i_rk_req = 1'b0;
    model_expand(K1);
  endtask

  task automatic test_rekey();
    int n;
    logic [127:0] k3;
    k3 = {$urandom, $urandom, $urandom, $urandom};
    old_rk = exp_rk;
    model_expand(k3);
    i_key_valid = 1'b1;
    i_key = k3;
    i_rk_req = 1'b1;
    i_rk_idx = 4'd10;
    @(negedge clk);
    i_key_valid = 1'b0;
    i_rk_req = 1'b0;
    total++;
    if ({o_rk_valid, o_rk_err, o_rk_idx, o_roundkey, o_key_ready} !== {1'b1, 1'b0, 4'd10, old_rk[10], 1'b0}) begin
      bad++;
      $display("FAIL rekey_old got v=%b i=%0d k=%h rdy=%b want v=1 i=10 k=%h rdy=0",
               o_rk_valid, o_rk_idx, o_roundkey, o_key_ready, old_rk[10]);
    end
    wait_ready(n);
    total++;
    if (n != NR) begin
      bad++;
      $display("FAIL rekey_busy_len got %0d want %0d", n, NR);
    end
    i_rk_req = 1'b1;
    i_rk_idx = 4'd10;
    @(negedge clk);
    i_rk_req = 1'b0;
    total++;
    if ({o_rk_valid, o_rk_idx, o_roundkey} !== {1'b1, 4'd10, exp_rk[10]}) begin
      bad++;
      $display("FAIL rekey_new got v=%b i=%0d k=%h want k=%h", o_rk_valid, o_rk_idx, o_roundkey, exp_rk[10]);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    logic [127:0] k4;
    logic [127:0] k5;
    k4 = {$urandom, $urandom, $urandom, $urandom};
    k5 = {$urandom, $urandom, $urandom, $urandom};
    do_load(k4);
    repeat (4) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    total++;
    if ({o_rk_valid, o_rk_err, o_rk_idx, o_roundkey, o_key_ready} !== {1'b0, 1'b0, 4'd0, 128'd0, 1'b1}) begin
      bad++;
      $display("FAIL midreset_outputs got v=%b e=%b i=%0d k=%h rdy=%b want 0/0/0/0/1",
               o_rk_valid, o_rk_err, o_rk_idx, o_roundkey, o_key_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    i_rk_req = 1'b1;
    i_rk_idx = 4'd0;
    @(negedge clk);
    i_rk_req = 1'b0;
    total++;
    if ({o_rk_valid, o_rk_err, o_roundkey, o_key_ready} !== {1'b0, 1'b1, 128'd0, 1'b1}) begin
      bad++;
      $display("FAIL midreset_req got v=%b e=%b k=%h rdy=%b want v=0 e=1 k=0 rdy=1",
               o_rk_valid, o_rk_err, o_roundkey, o_key_ready);
    end
    model_expand(k5);
    do_load(k5);
    wait_ready(n);
    total++;
    if (n != NR) begin
      bad++;
      $display("FAIL midreset_reload_len got %0d want %0d", n, NR);
    end
    for (int i = 0; i <= NR; i++) begin
      i_rk_req = 1'b1;
      i_rk_idx = 4'(i);
      @(negedge clk);
      total++;
      if ({o_rk_valid, o_rk_err, o_rk_idx, o_roundkey} !== {1'b1, 1'b0, 4'(i), exp_rk[i]}) begin
        bad++;
        $display("FAIL midreset_reload got v=%b i=%0d k=%h want i=%0d k=%h",
                 o_rk_valid, o_rk_idx, o_roundkey, i, exp_rk[i]);
      end
    end
    i_rk_req = 1'b0;
  endtask

  task automatic test_ignore_during_expand();
    int n;
    logic [127:0] ka;
    logic [127:0] kb;
    ka = {$urandom, $urandom, $urandom, $urandom};
    kb = ~ka;
    model_expand(ka);
    old_rk = exp_rk;
    i_key_valid = 1'b1;
    i_key = ka;
    @(negedge clk);
    i_key = kb;
    wait_ready(n);
    total++;
    if (n != NR) begin
      bad++;
      $display("FAIL ignore_busy_len got %0d want %0d", n, NR);
    end
    i_rk_req = 1'b1;
    i_rk_idx = 4'd10;
    @(negedge clk);
    i_key_valid = 1'b0;
    i_rk_req = 1'b0;
    total++;
    if ({o_rk_valid, o_rk_idx, o_roundkey, o_key_ready} !== {1'b1, 4'd10, old_rk[10], 1'b0}) begin
      bad++;
      $display("FAIL ignore_first got v=%b i=%0d k=%h rdy=%b want v=1 k=%h rdy=0",
               o_rk_valid, o_rk_idx, o_roundkey, o_key_ready, old_rk[10]);
    end
    model_expand(kb);
    wait_ready(n);
    for (int i = 0; i <= NR; i++) begin
      i_rk_req = 1'b1;
      i_rk_idx = 4'(i);
      @(negedge clk);
      total++;
      if ({o_rk_valid, o_rk_idx, o_roundkey} !== {1'b1, 4'(i), exp_rk[i]}) begin
        bad++;
        $display("FAIL ignore_second got v=%b i=%0d k=%h want i=%0d k=%h",
                 o_rk_valid, o_rk_idx, o_roundkey, i, exp_rk[i]);
      end
    end
    i_rk_req = 1'b0;
    last_out = exp_rk[NR];
  endtask

  task automatic test_random_reads();
    int n;
    logic       r;
    logic [3:0] id;
    logic [127:0] kr;
    for (int t = 0; t < 3; t++) begin
      kr = {$urandom, $urandom, $urandom, $urandom};
      model_expand(kr);
      do_load(kr);
      wait_ready(n);
      for (int c = 0; c < 40; c++) begin
        r  = ($urandom_range(0, 3) != 0);
        id = 4'($urandom_range(0, 15));
        i_rk_req = r;
        i_rk_idx = id;
        @(negedge clk);
        total++;
        if (r && id <= 4'd10) begin
          if ({o_rk_valid, o_rk_err, o_rk_idx, o_roundkey} !== {1'b1, 1'b0, id, exp_rk[id]}) begin
            bad++;
            $display("FAIL rand_read got v=%b e=%b i=%0d k=%h want i=%0d k=%h",
                     o_rk_valid, o_rk_err, o_rk_idx, o_roundkey, id, exp_rk[id]);
          end
          last_out = exp_rk[id];
        end else if ({o_rk_valid, o_rk_err, o_roundkey} !== {1'b0, r, last_out}) begin
          bad++;
          $display("FAIL rand_noread req=%b idx=%0d got v=%b e=%b k=%h want v=0 e=%b k=%h",
                   r, id, o_rk_valid, o_rk_err, o_roundkey, r, last_out);
        end
      end
      i_rk_req = 1'b0;
    end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_fips();
    test_desc_burst();
    test_err();
    test_rekey();
    test_reset_mid();
    test_ignore_during_expand();
    test_random_reads();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/roundkey_gen.md
# roundkey_gen

Round-key producer for the AES-128 datapath: accepts a 128-bit cipher key, expands it iteratively into the NR+1 round keys, and serves them on a registered, indexed read port. Both cipher directions use it. The encryption round chain reads indices 0..NR. The decryption chain reads NR..0. Each key read feeds the round-key input of the add-round-key stage. Keys are stored once per key load and can then be read at one key per cycle, in any order.

## Interface
- WORD, 32: bits per word
- NB, 4: words per block and per round key (round key width = WORD*NB)
- NK, 4: words in cipher key (only 4 supported)
- NR, 10: number of rounds; stored keys = NR+1
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- i_key_valid  in  1  cipher key present on i_key
- i_key  in  WORD*NK  cipher key, word 0 in [127:96] (FIPS-197 byte order)
- o_key_ready  out  1  block can accept a key this cycle
- i_rk_req  in  1  round-key read request
- i_rk_idx  in  4  round index requested, 0..NR
- o_rk_valid  out  1  o_roundkey/o_rk_idx valid this cycle
- o_rk_idx  out  4  echo of the index being returned
- o_roundkey  out  WORD*NB  round key for o_rk_idx
- o_rk_err  out  1  one-cycle pulse: request was rejected (out-of-range index or not READY)

## Operation
- State machine with three states:
  - IDLE: after reset; no valid keys stored.
  - EXPAND: computing round keys; lasts NR cycles.
  - READY: all NR+1 keys stored and readable.
- o_key_ready = 1 in IDLE and READY, 0 in EXPAND. A key is accepted on an edge where i_key_valid & o_key_ready.
- On key accept:
  - rk[0] <= i_key; work register W <= i_key; rcon <= 8'h01; cnt <= 1.
  - State goes to EXPAND.
- Each EXPAND cycle, with W = {w0,w1,w2,w3}:
  - t = SubWord(RotWord(w3)) ^ {rcon, 24'h0}.
  - w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
  - rk[cnt] <= W'; W <= W'; rcon <= xtime(rcon), i.e. (rcon<<1) ^ (rcon[7] ? 8'h1b : 0), truncated to 8 bits; cnt <= cnt+1.
  - When cnt == NR, the state goes to READY on the same edge.
- SubWord uses four instances of the shared forward S-box (combinational). RotWord is a left rotation by one byte.
- Reads:
  - A request is serviced only if the state is READY at the request edge and i_rk_idx <= NR. The next cycle then shows o_rk_valid=1, o_rk_idx=i_rk_idx, o_roundkey=rk[i_rk_idx].
  - If the index is > NR, or the state is not READY: next cycle o_rk_valid=0, o_rk_err=1. o_roundkey holds its previous value.
  - No request: o_rk_valid=0, o_rk_err=0, o_roundkey holds.
- Back-to-back requests are serviced at full rate, with no bubbles.
- New key while READY:
  - The key is accepted, all stored keys become stale, and the state goes to EXPAND.
  - A request on the accept edge is still serviced from the old array contents.
  - Requests during EXPAND are rejected with o_rk_err.
- i_key_valid during EXPAND is ignored (not queued).

## Timing
- Reset (asynchronous assert, released synchronously by the reset tree):
  - state IDLE; W, rcon, cnt, and rk[0..NR] cleared.
  - o_rk_valid=0, o_rk_err=0, o_rk_idx=0, o_roundkey=0.
  - o_key_ready=1 (combinational from state).
- Key accepted at edge E0: rk[i] is written at edge Ei for i=1..NR, and the state is READY after edge E10 (for NR=10). The first serviceable request is sampled at edge E11, giving data in the cycle after E11.
- Key-load to first data is NR+1 cycles.
- Read latency is exactly 1 cycle, with registered outputs.
- Reset mid-EXPAND or mid-read aborts immediately: the state is IDLE and all outputs take their reset values.

## Test plan
- Load 2b7e151628aed2a6abf7158809cf4f3c; wait for READY; read idx 0, 1, 10 on consecutive cycles. Required: 2b7e1516..., then a0fafe1788542cb123a339392a6c7605, then d014f9a8c9ee2589e13f0cc8b6630ca6, all in consecutive cycles with o_rk_valid=1 and the correct o_rk_idx.
- Load 000102030405060708090a0b0c0d0e0f; read 10..0 as a descending burst. Required: idx 10 = 13111d7fe3944a17f307a78b4d2b30c5; eleven consecutive valid cycles with no gaps.
- Request idx 3 two cycles after key accept (during EXPAND), and idx 11 in READY. Required: o_rk_err pulse, o_rk_valid=0, and o_roundkey unchanged in both cases; o_key_ready=0 during EXPAND.
- In READY, assert a new key and read idx 10 on the same edge. Required: the old key's round-10 value is returned; o_key_ready drops for 10 cycles; afterwards idx 10 returns the new key's value.
- Assert rst while cnt=5 in EXPAND. Required: all outputs 0 and o_key_ready=1 immediately; after a reload, correct keys are produced; requests before the reload get o_rk_err.
- Hold i_key_valid high throughout EXPAND with a different key. Required: it is ignored until READY, then accepted once o_key_ready=1.
